// File: rtl/vt100_pkg.sv
// Shared VT100 definitions: special-key codes, escape-sequence bytes and encoder types.
package vt100_pkg;

    // Special-key codes delivered alongside keySpecial=1
    typedef enum logic [7:0] {
        UP     = 8'h01,
        DOWN   = 8'h02,
        RIGHT  = 8'h03,
        LEFT   = 8'h04,
        HOME   = 8'h05,
        END    = 8'h06,
        INSERT = 8'h07,
        DELETE = 8'h08,
        PGUP   = 8'h09,
        PGDN   = 8'h0A,
        F1     = 8'h11,
        F2     = 8'h12,
        F3     = 8'h13,
        F4     = 8'h14
    } Vt100Key_t;

    localparam logic [7:0] ESC         = 8'h1B;
    localparam logic [7:0] CSI_BRACKET = 8'h5B;
    localparam logic [7:0] SS3_O       = 8'h4F;
    localparam logic [7:0] TILDE       = 8'h7E;

    localparam int unsigned MAX_SEQ_LEN = 4;
    localparam int unsigned SEQ_LEN_W   = 3;
    localparam int unsigned SEQ_IDX_W   = 2;

    // One encoded key: byte 0 is sent first, len=0 means "nothing to send"
    typedef struct packed {
        logic [SEQ_LEN_W-1:0]            len;
        logic [MAX_SEQ_LEN-1:0][7:0]     bytes;
    } key_seq_t;

    typedef enum logic {
        E_IDLE,
        E_EMIT
    } enc_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_GUARD,
        T_WAIT
    } tx_state_t;

    // ESC [ <final>
    function automatic key_seq_t csi_seq(input logic [7:0] final_b);
        key_seq_t s;
        s.len      = SEQ_LEN_W'(3);
        s.bytes    = '0;
        s.bytes[0] = ESC;
        s.bytes[1] = CSI_BRACKET;
        s.bytes[2] = final_b;
        return s;
    endfunction

    // ESC [ <digit> ~
    function automatic key_seq_t tilde_seq(input logic [7:0] digit);
        key_seq_t s;
        s.len      = SEQ_LEN_W'(4);
        s.bytes    = '0;
        s.bytes[0] = ESC;
        s.bytes[1] = CSI_BRACKET;
        s.bytes[2] = digit;
        s.bytes[3] = TILDE;
        return s;
    endfunction

    // ESC O <final>
    function automatic key_seq_t ss3_seq(input logic [7:0] final_b);
        key_seq_t s;
        s.len      = SEQ_LEN_W'(3);
        s.bytes    = '0;
        s.bytes[0] = ESC;
        s.bytes[1] = SS3_O;
        s.bytes[2] = final_b;
        return s;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO between the key encoder and the UART pacer; head byte visible on dout.
module tx_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer/level state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/vt100_key_encoder.sv
// Key event -> VT100 byte sequence encoder, byte FIFO and start/busy UART pacing.
module vt100_key_encoder
    import vt100_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          ENTER_CRLF = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         keyValid,
    input  logic                         keySpecial,
    input  logic [7:0]                   keyCode,
    output logic                         keyReady,
    output logic                         keyDropped,
    output logic                         txStart,
    output logic [7:0]                   txData,
    input  logic                         txBusy,
    output logic [$clog2(FIFO_DEPTH):0]  fifoLevel
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    // Highest occupancy that still leaves room for a full-length sequence
    localparam logic [LVL_W-1:0] READY_MAX_LVL = LVL_W'(FIFO_DEPTH - MAX_SEQ_LEN);

    // Encode table: ASCII passes through, specials expand, unknown specials give nothing
    function automatic key_seq_t encode_key(input logic special, input logic [7:0] code);
        key_seq_t s;
        s.len   = '0;
        s.bytes = '0;
        if (special) begin
            case (code)
                UP:      s = csi_seq(8'h41);
                DOWN:    s = csi_seq(8'h42);
                RIGHT:   s = csi_seq(8'h43);
                LEFT:    s = csi_seq(8'h44);
                HOME:    s = csi_seq(8'h48);
                END:     s = csi_seq(8'h46);
                INSERT:  s = tilde_seq(8'h32);
                DELETE:  s = tilde_seq(8'h33);
                PGUP:    s = tilde_seq(8'h35);
                PGDN:    s = tilde_seq(8'h36);
                F1:      s = ss3_seq(8'h50);
                F2:      s = ss3_seq(8'h51);
                F3:      s = ss3_seq(8'h52);
                F4:      s = ss3_seq(8'h53);
                default: s.len = '0;
            endcase
        end else begin
            s.bytes[0] = code;
            s.len      = SEQ_LEN_W'(1);
            if (ENTER_CRLF && (code == 8'h0D)) begin
                s.bytes[1] = 8'h0A;
                s.len      = SEQ_LEN_W'(2);
            end
        end
        return s;
    endfunction

    enc_state_t           enc_state_q, enc_state_d;
    key_seq_t             seq_q, seq_d;
    logic [SEQ_IDX_W-1:0] idx_q, idx_d;
    logic                 keyReady_q, keyReady_d;
    logic                 keyDropped_q, keyDropped_d;

    tx_state_t            tx_state_q, tx_state_d;
    logic                 txStart_q, txStart_d;
    logic [7:0]           txData_q, txData_d;

    key_seq_t             new_seq;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_din;
    logic [7:0]           fifo_dout;
    logic [LVL_W-1:0]     fifo_level;
    logic [LVL_W-1:0]     level_next;

    assign new_seq = encode_key(keySpecial, keyCode);

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .level (fifo_level)
    );

    // ENC FSM: latch an accepted sequence, then push one byte per cycle
    always_comb begin
        enc_state_d  = enc_state_q;
        seq_d        = seq_q;
        idx_d        = idx_q;
        keyDropped_d = 1'b0;
        fifo_push    = 1'b0;
        fifo_din     = seq_q.bytes[idx_q];
        case (enc_state_q)
            E_IDLE: begin
                // keyReady implies idle; a zero-length (unknown) code is consumed silently
                if (keyValid && keyReady_q && (new_seq.len != '0)) begin
                    seq_d       = new_seq;
                    idx_d       = '0;
                    enc_state_d = E_EMIT;
                end
            end
            E_EMIT: begin
                fifo_push = 1'b1;
                if (SEQ_LEN_W'(idx_q) == (seq_q.len - SEQ_LEN_W'(1))) begin
                    enc_state_d = E_IDLE;
                end else begin
                    idx_d = idx_q + SEQ_IDX_W'(1);
                end
            end
            default: enc_state_d = E_IDLE;
        endcase
        if (keyValid && !keyReady_q) keyDropped_d = 1'b1;
    end

    // Readiness for the coming cycle, from next ENC state and next FIFO occupancy
    always_comb begin
        level_next = fifo_level + LVL_W'(fifo_push) - LVL_W'(fifo_pop);
        keyReady_d = (enc_state_d == E_IDLE) && (level_next <= READY_MAX_LVL);
    end

    // ENC state and encoder outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_state_q  <= E_IDLE;
            seq_q        <= '0;
            idx_q        <= '0;
            keyReady_q   <= 1'b0;
            keyDropped_q <= 1'b0;
        end else begin
            enc_state_q  <= enc_state_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            keyReady_q   <= keyReady_d;
            keyDropped_q <= keyDropped_d;
        end
    end

    // TX FSM: pop head on idle transmitter, skip one cycle of busy, wait for busy to drop
    always_comb begin
        tx_state_d = tx_state_q;
        txStart_d  = 1'b0;
        txData_d   = txData_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if ((fifo_level != '0) && !txBusy) begin
                    fifo_pop   = 1'b1;
                    txData_d   = fifo_dout;
                    txStart_d  = 1'b1;
                    tx_state_d = T_GUARD;
                end
            end
            T_GUARD: tx_state_d = T_WAIT;
            T_WAIT: begin
                if (!txBusy) tx_state_d = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // TX state and transmitter-facing outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= T_IDLE;
            txStart_q  <= 1'b0;
            txData_q   <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            txStart_q  <= txStart_d;
            txData_q   <= txData_d;
        end
    end

    assign keyReady   = keyReady_q;
    assign keyDropped = keyDropped_q;
    assign txStart    = txStart_q;
    assign txData     = txData_q;
    assign fifoLevel  = fifo_level;

endmodule

// File: tb/tb_vt100_key_encoder.sv
// Scoreboard bench for vt100_key_encoder with a simple start/busy transmitter model.
module tb_vt100_key_encoder;

    localparam int unsigned DEPTH    = 16;
    localparam bit          CRLF     = 1'b1;
    localparam int          BUSY_CYC = 3;

    logic       clk;
    logic       rst;
    logic       keyValid;
    logic       keySpecial;
    logic [7:0] keyCode;
    logic       keyReady;
    logic       keyDropped;
    logic       txStart;
    logic [7:0] txData;
    logic       txBusy;
    logic [4:0] fifoLevel;

    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    logic       hold_busy;
    int         busy_cnt;

    vt100_key_encoder #(
        .FIFO_DEPTH (DEPTH),
        .ENTER_CRLF (CRLF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keyValid   (keyValid),
        .keySpecial (keySpecial),
        .keyCode    (keyCode),
        .keyReady   (keyReady),
        .keyDropped (keyDropped),
        .txStart    (txStart),
        .txData     (txData),
        .txBusy     (txBusy),
        .fifoLevel  (fifoLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference encoding, pushed into the scoreboard when a key is accepted
    task automatic push_exp(input logic sp, input logic [7:0] c);
        logic [31:0] s;
        int          n;
        s = 32'h0;
        n = 0;
        if (!sp) begin
            s = {c, 24'h0};
            n = 1;
            if (c == 8'h0D && CRLF) begin
                s[23:16] = 8'h0A;
                n = 2;
            end
        end else begin
            case (c)
                8'h01: begin s = 32'h1B5B4100; n = 3; end
                8'h02: begin s = 32'h1B5B4200; n = 3; end
                8'h03: begin s = 32'h1B5B4300; n = 3; end
                8'h04: begin s = 32'h1B5B4400; n = 3; end
                8'h05: begin s = 32'h1B5B4800; n = 3; end
                8'h06: begin s = 32'h1B5B4600; n = 3; end
                8'h07: begin s = 32'h1B5B327E; n = 4; end
                8'h08: begin s = 32'h1B5B337E; n = 4; end
                8'h09: begin s = 32'h1B5B357E; n = 4; end
                8'h0A: begin s = 32'h1B5B367E; n = 4; end
                8'h11: begin s = 32'h1B4F5000; n = 3; end
                8'h12: begin s = 32'h1B4F5100; n = 3; end
                8'h13: begin s = 32'h1B4F5200; n = 3; end
                8'h14: begin s = 32'h1B4F5300; n = 3; end
                default: n = 0;
            endcase
        end
        for (int i = 0; i < n; i++) exp_q.push_back(s[31-8*i -: 8]);
    endtask

    // Drive one key event; returns on the negedge after the sampling edge
    task automatic send_key(input string tag, input logic sp, input logic [7:0] c, input logic acc);
        int n;
        n = 0;
        if (acc) begin
            while (keyReady !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check({"rdy_", tag}, 32'(keyReady), 32'(acc));
        keyValid   = 1'b1;
        keySpecial = sp;
        keyCode    = c;
        @(negedge clk);
        keyValid   = 1'b0;
        check({"drop_", tag}, 32'(keyDropped), 32'(!acc));
        if (acc) push_exp(sp, c);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifoLevel != 5'd0 || txBusy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
        check({"lvl_", tag}, 32'(fifoLevel), 32'd0);
    endtask

    // Transmitter model and output scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt = 0;
        end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (dut.fifo_push) check("push_full", 32'(dut.fifo_level == 5'(DEPTH)), 32'd0);
            if (dut.fifo_pop)  check("pop_empty", 32'(dut.fifo_level == 5'd0), 32'd0);
            if (txStart) begin
                check("busy_at_start", 32'(txBusy), 32'd0);
                check("unexpected_start", 32'(exp_q.size() == 0), 32'd0);
                if (exp_q.size() != 0) check("tx_byte", 32'(txData), 32'(exp_q.pop_front()));
                busy_cnt = BUSY_CYC;
            end
        end
        txBusy = hold_busy || (busy_cnt > 0);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        hold_busy  = 1'b0;
        busy_cnt   = 0;
        txBusy     = 1'b0;
        keyValid   = 1'b0;
        keySpecial = 1'b0;
        keyCode    = 8'h00;
        rst        = 1'b0;
        repeat (3) @(negedge clk);

        // Values held in reset
        check("rst_ready", 32'(keyReady), 32'd0);
        check("rst_drop",  32'(keyDropped), 32'd0);
        check("rst_start", 32'(txStart), 32'd0);
        check("rst_data",  32'(txData), 32'd0);
        check("rst_level", 32'(fifoLevel), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(keyReady), 32'd1);

        // Plain ASCII and its start latency
        send_key("a", 1'b0, 8'h61, 1'b1);
        @(negedge clk);
        check("lat_a_early", 32'(txStart), 32'd0);
        @(negedge clk);
        check("lat_a", 32'(txStart), 32'd1);
        drain("a");

        // Cursor key: ready drops for exactly the emit cycles
        send_key("up", 1'b1, 8'h01, 1'b1);
        check("up_rdy_c1", 32'(keyReady), 32'd0);
        @(negedge clk);
        check("up_rdy_c2", 32'(keyReady), 32'd0);
        @(negedge clk);
        check("up_rdy_c3", 32'(keyReady), 32'd0);
        @(negedge clk);
        check("up_rdy_c4", 32'(keyReady), 32'd1);
        drain("up");

        // Four-byte sequence, Enter expansion and a function key
        send_key("del", 1'b1, 8'h08, 1'b1);
        send_key("cr",  1'b0, 8'h0D, 1'b1);
        send_key("f4",  1'b1, 8'h14, 1'b1);
        send_key("end", 1'b1, 8'h06, 1'b1);
        drain("mix");

        // Fill with transmitter held busy until a key no longer fits
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) send_key("fill", 1'b1, 8'h01, 1'b1);
        repeat (5) @(negedge clk);
        check("fill_level", 32'(fifoLevel), 32'd15);
        send_key("full", 1'b1, 8'h01, 1'b0);
        repeat (4) @(negedge clk);
        check("full_level", 32'(fifoLevel), 32'd15);
        hold_busy = 1'b0;
        drain("fill");

        // Key during emission is dropped; unknown special is consumed silently
        send_key("pgup", 1'b1, 8'h09, 1'b1);
        send_key("in_emit", 1'b0, 8'h78, 1'b0);
        send_key("unknown", 1'b1, 8'h7F, 1'b1);
        @(negedge clk);
        check("unknown_drop", 32'(keyDropped), 32'd0);
        drain("emit");

        // Reset in the middle of draining a queued burst
        hold_busy = 1'b1;
        @(negedge clk);
        send_key("q1", 1'b1, 8'h02, 1'b1);
        send_key("q2", 1'b1, 8'h03, 1'b1);
        for (int n = 0; n < 50 && fifoLevel != 5'd6; n++) @(negedge clk);
        check("q_level", 32'(fifoLevel), 32'd6);
        hold_busy = 1'b0;
        for (int n = 0; n < 200 && exp_q.size() > 4; n++) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_ready", 32'(keyReady), 32'd0);
        check("mid_rst_drop",  32'(keyDropped), 32'd0);
        check("mid_rst_start", 32'(txStart), 32'd0);
        check("mid_rst_data",  32'(txData), 32'd0);
        check("mid_rst_level", 32'(fifoLevel), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy1", 32'(keyReady), 32'd1);
        send_key("b", 1'b0, 8'h62, 1'b1);
        drain("b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
